// File: rtl/tpu_op_sequencer.sv
// Operation sequencer for one systolic matrix-multiply pass: weight load, input feed,
// array drain, output write, with a per-phase done timeout and host completion report.
module tpu_op_sequencer #(
  parameter int unsigned addr_width     = 8,
  parameter int unsigned width_height   = 16,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [addr_width-1:0]           cmd_weight_addr,
  input  logic [addr_width-1:0]           cmd_input_addr,
  input  logic [addr_width-1:0]           cmd_output_addr,
  input  logic [$clog2(width_height)-1:0] cmd_num_row,
  input  logic [$clog2(width_height)-1:0] cmd_num_col,
  output logic                            weight_active,
  output logic                            input_active,
  output logic                            output_active,
  output logic [addr_width-1:0]           weight_base_addr,
  output logic [addr_width-1:0]           input_base_addr,
  output logic [addr_width-1:0]           output_base_addr,
  output logic [$clog2(width_height)-1:0] num_row,
  output logic [$clog2(width_height)-1:0] num_col,
  input  logic                            weight_done,
  input  logic                            input_done,
  input  logic                            output_done,
  output logic                            busy,
  output logic                            op_done,
  output logic                            op_error
);

  localparam int unsigned ext_w = $clog2(width_height);
  // Two extra bits so num_row+num_col+2 never wraps, even at full extents.
  localparam int unsigned cnt_w = ext_w + 2;
  localparam int unsigned tmr_w = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [tmr_w-1:0] tmr_last = tmr_w'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [tmr_w-1:0] timer;
  logic [cnt_w-1:0] drain_cnt;
  logic             phase_done;
  logic             timed_out;

  // A done counts only in its own phase and never in the cycle of its start pulse.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      LOAD_W:  phase_done = weight_done && !weight_active;
      FEED:    phase_done = input_done && !input_active;
      WRITE:   phase_done = output_done && !output_active;
      default: phase_done = 1'b0;
    endcase
  end

  assign timed_out = (timer == tmr_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      weight_active    <= 1'b0;
      input_active     <= 1'b0;
      output_active    <= 1'b0;
      op_done          <= 1'b0;
      op_error         <= 1'b0;
      weight_base_addr <= '0;
      input_base_addr  <= '0;
      output_base_addr <= '0;
      num_row          <= '0;
      num_col          <= '0;
      timer            <= '0;
      drain_cnt        <= '0;
    end else begin
      weight_active <= 1'b0;
      input_active  <= 1'b0;
      output_active <= 1'b0;
      op_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            weight_base_addr <= cmd_weight_addr;
            input_base_addr  <= cmd_input_addr;
            output_base_addr <= cmd_output_addr;
            num_row          <= cmd_num_row;
            num_col          <= cmd_num_col;
            op_error         <= 1'b0;
            timer            <= '0;
            weight_active    <= 1'b1;
            cmd_ready        <= 1'b0;
            busy             <= 1'b1;
            state            <= LOAD_W;
          end
        end
        LOAD_W, FEED, WRITE: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (phase_done) begin
            timer <= '0;
            if (state == LOAD_W) begin
              input_active <= 1'b1;
              state        <= FEED;
            end else if (state == FEED) begin
              drain_cnt <= cnt_w'(num_row) + cnt_w'(num_col) + cnt_w'(2);
              state     <= DRAIN;
            end else begin
              op_done <= 1'b1;
              state   <= DONE;
            end
          end else if (timed_out) begin
            op_done  <= 1'b1;
            op_error <= 1'b1;
            state    <= DONE;
          end else begin
            timer <= timer + tmr_w'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == cnt_w'(1)) begin
            output_active <= 1'b1;
            timer         <= '0;
            state         <= WRITE;
          end else begin
            drain_cnt <= drain_cnt - cnt_w'(1);
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_op_sequencer.sv
// Self-checking bench for tpu_op_sequencer: phase/age reference model compared every cycle,
// directed scenarios with literal timing checks, then randomized traffic with noise and resets.
module tb_tpu_op_sequencer;

  localparam int unsigned AW = 8;
  localparam int unsigned WH = 16;
  localparam int unsigned EW = 4;
  localparam int          TO = 16;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_weight_addr, cmd_input_addr, cmd_output_addr;
  logic [EW-1:0] cmd_num_row, cmd_num_col;
  logic          weight_active, input_active, output_active;
  logic [AW-1:0] weight_base_addr, input_base_addr, output_base_addr;
  logic [EW-1:0] num_row, num_col;
  logic          weight_done, input_done, output_done;
  logic          busy, op_done, op_error;

  tpu_op_sequencer #(.addr_width(AW), .width_height(WH), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weight_addr(cmd_weight_addr), .cmd_input_addr(cmd_input_addr),
    .cmd_output_addr(cmd_output_addr), .cmd_num_row(cmd_num_row), .cmd_num_col(cmd_num_col),
    .weight_active(weight_active), .input_active(input_active), .output_active(output_active),
    .weight_base_addr(weight_base_addr), .input_base_addr(input_base_addr),
    .output_base_addr(output_base_addr), .num_row(num_row), .num_col(num_col),
    .weight_done(weight_done), .input_done(input_done), .output_done(output_done),
    .busy(busy), .op_done(op_done), .op_error(op_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Reference model: phase 0 idle,1 weight,2 feed,3 drain,4 write,5 done; age = cycles in phase.
  int      m_phase = 0, m_age = 0, m_nr = 0, m_nc = 0;
  int      m_wa = 0, m_ia = 0, m_oa = 0;
  bit      m_err = 0, m_valid = 0;

  // Stimulus knobs.
  bit k_reset = 1, k_valid = 0, k_rand = 0, k_noise = 0, k_rand_dly = 0, k_rand_rst = 0;
  bit k_same_w = 0, k_stray = 0;
  int k_dly_w = 5, k_dly_i = 5, k_dly_o = 5;
  int f_wa = 0, f_ia = 0, f_oa = 0, f_nr = 0, f_nc = 0;
  int c_w = -1, c_i = -1, c_o = -1;

  // Observed DUT events.
  int last_w = -100, last_i = -100, last_o = -100, last_done = -100;
  int n_w = 0, n_i = 0, n_o = 0, n_done = 0;
  bit last_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("weight_active", 32'(weight_active), 32'(m_phase == 1 && m_age == 0));
    chk("input_active", 32'(input_active), 32'(m_phase == 2 && m_age == 0));
    chk("output_active", 32'(output_active), 32'(m_phase == 4 && m_age == 0));
    chk("op_done", 32'(op_done), 32'(m_phase == 5));
    chk("op_error", 32'(op_error), 32'(m_err));
    chk("weight_base_addr", 32'(weight_base_addr), 32'(m_wa));
    chk("input_base_addr", 32'(input_base_addr), 32'(m_ia));
    chk("output_base_addr", 32'(output_base_addr), 32'(m_oa));
    chk("num_row", 32'(num_row), 32'(m_nr));
    chk("num_col", 32'(num_col), 32'(m_nc));
  endtask

  task automatic respond(input bit act, input int dly, inout int c, output bit d);
    if (act) c = dly;
    d = 1'b0;
    if (c == 0) begin
      d = 1'b1;
      c = -1;
    end else if (c > 0) begin
      c--;
    end
  endtask

  function automatic int pick_dly(input int fixed);
    return k_rand_dly ? int'($urandom_range(0, 17)) : fixed;
  endfunction

  function automatic bit noise();
    return k_noise && ($urandom_range(0, 7) == 0);
  endfunction

  task automatic model_update();
    bit d;
    if (reset) begin
      m_phase = 0; m_age = 0; m_err = 0; m_valid = 1;
      m_wa = 0; m_ia = 0; m_oa = 0; m_nr = 0; m_nc = 0;
    end else if (m_valid) begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_wa = int'(cmd_weight_addr); m_ia = int'(cmd_input_addr); m_oa = int'(cmd_output_addr);
          m_nr = int'(cmd_num_row); m_nc = int'(cmd_num_col);
          m_err = 0; m_phase = 1; m_age = 0;
        end
        1, 2, 4: begin
          d = (m_phase == 1) ? weight_done : (m_phase == 2) ? input_done : output_done;
          if (m_age >= 1 && d) begin
            m_phase = (m_phase == 4) ? 5 : m_phase + 1;
            m_age = 0;
          end else if (m_age == TO - 1) begin
            m_phase = 5; m_err = 1; m_age = 0;
          end else begin
            m_age++;
          end
        end
        3: if (m_age == m_nr + m_nc + 1) begin
          m_phase = 4; m_age = 0;
        end else begin
          m_age++;
        end
        default: begin
          m_phase = 0; m_age = 0;
        end
      endcase
    end
  endtask

  // One clock: check outputs, log events, drive next inputs, advance the model.
  task automatic step();
    bit dw, di, d_o, stray;
    @(negedge clk);
    if (m_valid) compare_all();
    if (weight_active === 1'b1) begin last_w = cyc; n_w++; end
    if (input_active === 1'b1) begin last_i = cyc; n_i++; end
    if (output_active === 1'b1) begin last_o = cyc; n_o++; end
    if (op_done === 1'b1) begin last_done = cyc; n_done++; last_err = op_error; end
    respond(weight_active === 1'b1, pick_dly(k_dly_w), c_w, dw);
    respond(input_active === 1'b1, pick_dly(k_dly_i), c_i, di);
    respond(output_active === 1'b1, pick_dly(k_dly_o), c_o, d_o);
    stray = k_stray && (cyc == last_i + 2);
    weight_done = dw | (k_same_w && weight_active === 1'b1) | stray | noise();
    input_done  = di | noise();
    output_done = d_o | stray | noise();
    cmd_valid = k_rand_dly ? ($urandom_range(0, 3) != 0) : k_valid;
    cmd_weight_addr = k_rand ? AW'($urandom) : AW'(f_wa);
    cmd_input_addr  = k_rand ? AW'($urandom) : AW'(f_ia);
    cmd_output_addr = k_rand ? AW'($urandom) : AW'(f_oa);
    cmd_num_row     = k_rand ? EW'($urandom) : EW'(f_nr);
    cmd_num_col     = k_rand ? EW'($urandom) : EW'(f_nc);
    reset = k_reset || (k_rand_rst && $urandom_range(0, 299) == 0);
    if (reset) begin c_w = -1; c_i = -1; c_o = -1; end
    model_update();
    cyc++;
  endtask

  task automatic wait_done(input int limit);
    int start;
    start = n_done;
    for (int i = 0; i < limit && n_done == start; i++) step();
    chk("op_completes_in_bound", 32'(n_done - start), 32'd1);
    step();
  endtask

  task automatic run_op(input int wa, input int ia, input int oa, input int nr, input int nc,
                        output int acc);
    f_wa = wa; f_ia = ia; f_oa = oa; f_nr = nr; f_nc = nc;
    acc = cyc;
    k_valid = 1; step(); k_valid = 0;
    wait_done(300);
  endtask

  initial begin
    int acc, o_before, w0, d0;
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_weight_addr = '0; cmd_input_addr = '0; cmd_output_addr = '0;
    cmd_num_row = '0; cmd_num_col = '0;
    weight_done = 1'b0; input_done = 1'b0; output_done = 1'b0;

    // Reset state.
    step(); step(); k_reset = 0; step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_error", 32'(op_error), 32'd0);
    chk("rst_weight_base", 32'(weight_base_addr), 32'd0);

    // Nominal pass.
    run_op(8'h10, 8'h20, 8'h30, 3, 3, acc);
    chk("nom_accept_to_w", 32'(last_w - acc), 32'd1);
    chk("nom_w_to_i", 32'(last_i - last_w), 32'd6);
    chk("nom_i_to_o", 32'(last_o - last_i), 32'd14);
    chk("nom_o_to_done", 32'(last_done - last_o), 32'd6);
    chk("nom_err", 32'(last_err), 32'd0);
    chk("nom_weight_base", 32'(weight_base_addr), 32'h10);
    chk("nom_output_base", 32'(output_base_addr), 32'h30);

    // Extent extremes: drain of 2 and 32 cycles.
    run_op(1, 2, 3, 0, 0, acc);
    chk("ext_min_i_to_o", 32'(last_o - last_i), 32'd8);
    run_op(4, 5, 6, 15, 15, acc);
    chk("ext_max_i_to_o", 32'(last_o - last_i), 32'd38);

    // Stray output_done in FEED, weight_done in the pulse cycle.
    k_stray = 1; k_same_w = 1; k_dly_w = 4;
    run_op(8'h10, 8'h20, 8'h30, 3, 3, acc);
    chk("same_cycle_w_to_i", 32'(last_i - last_w), 32'd5);
    chk("stray_i_to_o", 32'(last_o - last_i), 32'd14);
    k_stray = 0; k_same_w = 0; k_dly_w = 5;

    // Timeout in FEED.
    k_dly_i = -1; o_before = n_o;
    run_op(7, 8, 9, 2, 2, acc);
    chk("to_i_to_done", 32'(last_done - last_i), 32'd16);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_no_output_active", 32'(n_o - o_before), 32'd0);
    chk("to_err_held", 32'(op_error), 32'd1);
    k_dly_i = 5;
    k_valid = 1; step(); k_valid = 0; step();
    chk("to_err_cleared", 32'(op_error), 32'd0);
    wait_done(300);

    // Reset during DRAIN.
    k_valid = 1; step(); k_valid = 0;
    for (int i = 0; i < 100 && !(m_phase == 3 && m_age == 2); i++) step();
    chk("reached_drain", 32'(m_phase), 32'd3);
    o_before = n_o;
    k_reset = 1; step(); k_reset = 0; step();
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 60; i++) step();
    chk("mid_rst_no_output_active", 32'(n_o - o_before), 32'd0);

    // Continuous cmd_valid with changing fields.
    k_dly_w = 3; k_dly_i = 3; k_dly_o = 3;
    w0 = n_w; d0 = n_done;
    k_valid = 1; k_rand = 1;
    for (int i = 0; i < 300; i++) step();
    k_valid = 0;
    for (int i = 0; i < 200 && m_phase != 0; i++) step();
    chk("hs_one_accept_per_op", 32'(n_w - w0), 32'(n_done - d0));
    chk("hs_several_ops", 32'((n_done - d0) >= 5), 32'd1);

    // Randomized traffic with done noise, random delays and occasional resets.
    k_noise = 1; k_rand_dly = 1; k_rand_rst = 1;
    for (int i = 0; i < 4000; i++) step();
    k_noise = 0; k_rand_dly = 0; k_rand_rst = 0; k_rand = 0;
    for (int i = 0; i < 300 && m_phase != 0; i++) step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
